crop_scheduler: RTL

CROP_SCHEDULER -- requirements
Module: crop_scheduler

---
 rtl/crop_scheduler.sv | 138 +++++++++++++
 1 files changed

// File: rtl/crop_scheduler.sv
// Crop request scheduler: round-robin grant, bounds check and
// beat accounting for a single crop core.
module crop_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int IN_ROWS  = 40,
  parameter int IN_COLS  = 40,
  parameter int OUT_ROWS = 20,
  parameter int OUT_COLS = 20,
  parameter int COORD_W  = 8,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*COORD_W-1:0] req_y1,
  input  logic [NUM_REQ*COORD_W-1:0] req_x1,
  output logic [COORD_W-1:0]         cfg_y1,
  output logic [COORD_W-1:0]         cfg_x1,
  output logic                       cfg_load,
  output logic                       in_gate,
  input  logic                       in_fire,
  input  logic                       out_fire,
  output logic                       busy,
  output logic                       done_valid,
  output logic [IDX_W-1:0]           done_id,
  output logic                       done_err,
  input  logic                       done_ready
);

  localparam int IN_TOT  = IN_ROWS * IN_COLS;
  localparam int OUT_TOT = OUT_ROWS * OUT_COLS;
  localparam int CNT_W   = $clog2(IN_TOT + 1);
  localparam int CW1     = COORD_W + 1;

  localparam logic [CNT_W-1:0] IN_TOT_C  = CNT_W'(IN_TOT);
  localparam logic [CNT_W-1:0] OUT_TOT_C = CNT_W'(OUT_TOT);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   cand;
  logic               found;
  logic               accept;
  logic               oob;
  logic [COORD_W-1:0] y_sel;
  logic [COORD_W-1:0] x_sel;
  logic [CNT_W-1:0]   in_cnt;
  logic [CNT_W-1:0]   out_cnt;
  logic [IDX_W-1:0]   id_q;
  logic               err_q;

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    grant = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign accept = found && (state == IDLE) && !reset;
  assign y_sel  = req_y1[grant*COORD_W +: COORD_W];
  assign x_sel  = req_x1[grant*COORD_W +: COORD_W];

  // one extra bit so x1=255 plus the window size cannot wrap
  assign oob =
    (({1'b0, y_sel} + CW1'(OUT_ROWS)) > CW1'(IN_ROWS)) ||
    (({1'b0, x_sel} + CW1'(OUT_COLS)) > CW1'(IN_COLS));

  assign req_ready = accept ? (NUM_REQ'(1) << grant) : '0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = oob ? DONE : LOAD;
      LOAD: state_nxt = RUN;
      RUN:
        if (in_cnt == IN_TOT_C && out_cnt == OUT_TOT_C)
          state_nxt = DONE;
      DONE: if (done_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      cfg_y1  <= '0;
      cfg_x1  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rr_ptr <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
        cfg_y1 <= y_sel;
        cfg_x1 <= x_sel;
        id_q   <= grant;
        err_q  <= oob;
      end
      if (state == LOAD) begin
        in_cnt  <= '0;
        out_cnt <= '0;
      end else if (state == RUN) begin
        if (in_fire && in_gate)
          in_cnt <= in_cnt + 1'b1;
        if (out_fire && out_cnt < OUT_TOT_C)
          out_cnt <= out_cnt + 1'b1;
      end
    end
  end

  assign cfg_load   = (state == LOAD);
  assign in_gate    = (state == RUN) && (in_cnt < IN_TOT_C);
  assign busy       = (state != IDLE);
  assign done_valid = (state == DONE);
  assign done_id    = id_q;
  assign done_err   = err_q;

endmodule
